pulse_width_capture: RTL

- Parametrised N-channel pulse-width capture for RC receiver inputs and sonar echoes.
- Each channel measures its active pulse width in microseconds and flags a timeout if the pulse runs too long.
- Completed results queue per channel and are drained one at a time through a valid/ready port into the Jetson SPI report path.
- Successor to the fixed 6-channel RC/echo capture: adds per-channel polarity, enable mask, timeout reporting, overrun flags and backpressure.

---
 rtl/pwc_pkg.sv | 19 +
 rtl/pwc_channel.sv | 141 ++++++++++++++
 rtl/pulse_width_capture.sv | 113 +++++++++++
 3 files changed

// File: rtl/pwc_pkg.sv
// pwc_pkg: shared types and helpers for pulse_width_capture.
// Holds the channel state enum, width helper and us divider.
package pwc_pkg;

  typedef enum logic [1:0] {
    S_ARM  = 2'd0,
    S_IDLE = 2'd1,
    S_MEAS = 2'd2
  } ch_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int us_div(input int hz);
    return hz / 1_000_000;
  endfunction

endpackage

// File: rtl/pwc_channel.sv
// pwc_channel: one capture lane (sync, polarity, FSM, us counter, holding reg).
// Ports: i_pulse/i_enable/i_clear_ovr/i_take in; o_pending/o_width/o_timeout/o_overrun out.
module pwc_channel
  import pwc_pkg::*;
#(
  parameter int   WIDTH       = 16,
  parameter int   DIV         = 50,
  parameter int   TIMEOUT_US  = 30000,
  parameter int   SYNC_STAGES = 2,
  parameter logic ACT_HIGH    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_pulse,
  input  logic             i_enable,
  input  logic             i_clear_ovr,
  input  logic             i_take,
  output logic             o_pending,
  output logic [WIDTH-1:0] o_width,
  output logic             o_timeout,
  output logic             o_overrun
);

  localparam int PW = clog2_min1(DIV);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] W_TO = WIDTH'(TIMEOUT_US);

  typedef struct packed {
    logic             timeout;
    logic [WIDTH-1:0] width;
  } res_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_prime;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_act;
  ch_state_e              r_state;
  ch_state_e              w_state_nx;
  logic [PW-1:0]          r_presc;
  logic [WIDTH-1:0]       r_cnt;
  logic                   w_new;
  logic                   w_new_to;
  res_t                   r_hold;
  logic                   r_pend;
  logic                   r_ovr;

  assign w_act = r_sync[SYNC_STAGES-1] ^ ~ACT_HIGH;

  // r_prime keeps ARM from trusting the reset value of the synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= {SYNC_STAGES{~ACT_HIGH}};
      r_prime <= '0;
      r_prev  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_pulse};
      r_prime <= {r_prime[SYNC_STAGES-2:0], 1'b1};
      r_prev  <= w_act;
      r_rise  <= w_act & ~r_prev;
      r_fall  <= ~w_act & r_prev;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_new      = 1'b0;
    w_new_to   = 1'b0;
    if (!i_enable) begin
      w_state_nx = S_ARM;
    end else begin
      unique case (r_state)
        S_ARM: begin
          if (&r_prime && !w_act) w_state_nx = S_IDLE;
        end
        S_IDLE: begin
          if (r_rise) w_state_nx = S_MEAS;
        end
        S_MEAS: begin
          if (r_cnt == W_TO) begin
            w_new      = 1'b1;
            w_new_to   = 1'b1;
            w_state_nx = S_ARM;
          end else if (r_fall) begin
            w_new      = 1'b1;
            w_state_nx = S_IDLE;
          end
        end
        default: w_state_nx = S_ARM;
      endcase
    end
  end

  // rise cycle is the first active cycle, so the prescaler starts at 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ARM;
      r_presc <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == S_IDLE && r_rise) begin
        r_presc <= PW'(1);
        r_cnt   <= '0;
      end else if (r_state == S_MEAS) begin
        if (r_presc == P_LAST) begin
          r_presc <= '0;
          r_cnt   <= r_cnt + WIDTH'(1);
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
      r_pend <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_new) begin
        r_hold.width   <= r_cnt;
        r_hold.timeout <= w_new_to;
      end
      if (!i_enable)   r_pend <= 1'b0;
      else if (w_new)  r_pend <= 1'b1;
      else if (i_take) r_pend <= 1'b0;
      r_ovr <= (r_ovr & ~i_clear_ovr) | (w_new & r_pend & ~i_take);
    end
  end

  assign o_pending = r_pend;
  assign o_width   = r_hold.width;
  assign o_timeout = r_hold.timeout;
  assign o_overrun = r_ovr;

endmodule

// File: rtl/pulse_width_capture.sv
// pulse_width_capture: N-channel pulse-width capture, round-robin drained.
// Ports: pulse_in/enable/clear_ovr/out_ready in; out_valid/out_chan/out_width/out_timeout/overrun out.
module pulse_width_capture
  import pwc_pkg::*;
#(
  parameter int                    CHANNELS    = 6,
  parameter int                    CLK_FREQ_HZ = 50_000_000,
  parameter int                    WIDTH       = 16,
  parameter int                    TIMEOUT_US  = 30000,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0]   ACTIVE_HIGH = {CHANNELS{1'b1}},
  localparam int                   CW          = clog2_min1(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] pulse_in,
  input  logic [CHANNELS-1:0] enable,
  input  logic                clear_ovr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       out_chan,
  output logic [WIDTH-1:0]    out_width,
  output logic                out_timeout,
  output logic [CHANNELS-1:0] overrun
);

  localparam int DIV = us_div(CLK_FREQ_HZ);

  logic [CHANNELS-1:0] w_pend;
  logic [CHANNELS-1:0] w_take;
  logic [CHANNELS-1:0] w_to;
  logic [WIDTH-1:0]    w_width [CHANNELS];
  logic [CW:0]         w_j;
  logic [CW-1:0]       w_pick;
  logic [CW-1:0]       w_ptr_nx;
  logic                w_any;
  logic                w_load;
  logic [CW-1:0]       r_ptr;
  logic                r_valid;
  logic [CW-1:0]       r_chan;
  logic [WIDTH-1:0]    r_width;
  logic                r_to;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwc_channel #(
      .WIDTH       (WIDTH),
      .DIV         (DIV),
      .TIMEOUT_US  (TIMEOUT_US),
      .SYNC_STAGES (SYNC_STAGES),
      .ACT_HIGH    (ACTIVE_HIGH[g])
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_pulse     (pulse_in[g]),
      .i_enable    (enable[g]),
      .i_clear_ovr (clear_ovr),
      .i_take      (w_take[g]),
      .o_pending   (w_pend[g]),
      .o_width     (w_width[g]),
      .o_timeout   (w_to[g]),
      .o_overrun   (overrun[g])
    );
  end

  // scan from the farthest offset down so the nearest pending index wins
  always_comb begin
    w_j    = '0;
    w_any  = 1'b0;
    w_pick = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      w_j = {1'b0, r_ptr} + (CW+1)'(i);
      if (w_j >= (CW+1)'(CHANNELS)) w_j = w_j - (CW+1)'(CHANNELS);
      if (w_pend[w_j[CW-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_j[CW-1:0];
      end
    end
  end

  assign w_load   = w_any && (!r_valid || out_ready);
  assign w_ptr_nx = (w_pick == CW'(CHANNELS - 1)) ? '0 : w_pick + CW'(1);

  always_comb begin
    w_take = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_take[i] = w_load && (w_pick == CW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_chan  <= '0;
      r_width <= '0;
      r_to    <= 1'b0;
      r_ptr   <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_chan  <= w_pick;
      r_width <= w_width[w_pick];
      r_to    <= w_to[w_pick];
      r_ptr   <= w_ptr_nx;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_chan    = r_chan;
  assign out_width   = r_width;
  assign out_timeout = r_to;

endmodule
